// File: rtl/rr_arbiter4_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
package rr_arbiter4_pkg;

  localparam int ARB_N = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [ARB_N-1:0] onehot4(input logic [1:0] idx);
    logic [ARB_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter4_pick4.sv
// Combinational round-robin picker: searches last+1, last+2, last+3, last
// and returns the first requester found.
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] idx
);

  logic [1:0]       cand [ARB_N];
  logic [ARB_N-1:0] hit;

  // Candidate gi is the requester at priority rank gi (rank 0 = highest).
  genvar gi;
  generate
    for (gi = 0; gi < ARB_N; gi++) begin : g_cand
      assign cand[gi] = last + 2'(gi + 1);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Lowest-ranked hit wins; scanning downwards lets the best rank overwrite.
  always_comb begin
    any = |req;
    idx = cand[ARB_N-1];
    for (int k = ARB_N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx = cand[k];
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for one shared 4:1-multiplexed resource, with a hold
// watchdog that revokes grants lasting MAX_HOLD cycles without done.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_t state_reg, state_next;
  logic [1:0]       last_reg, last_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [3:0]       grant_reg, grant_next;
  logic [1:0]       sel_reg, sel_next;
  logic             busy_reg, busy_next;
  logic             timeout_reg, timeout_next;

  logic       pick_any;
  logic [1:0] pick_idx;
  logic [1:0] pick_last;
  logic       wd_expire;
  logic       release_now;

  // While granted, a release re-arbitrates as if last were already the
  // current owner, so the finisher drops to lowest priority immediately.
  assign pick_last = (state_reg == GRANT) ? sel_reg : last_reg;

  rr_pick4 u_pick (
    .req  (req),
    .last (pick_last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // done has precedence over the watchdog, so timeout only fires without done.
  assign wd_expire   = (MAX_HOLD > 0) && (state_reg == GRANT) &&
                       (hold_cnt_reg == HOLD_LAST) && !done;
  assign release_now = (state_reg == GRANT) && (done || wd_expire);

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    hold_cnt_next = hold_cnt_reg;
    grant_next    = grant_reg;
    sel_next      = sel_reg;
    busy_next     = busy_reg;
    timeout_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next    = GRANT;
          grant_next    = onehot4(pick_idx);
          sel_next      = pick_idx;
          busy_next     = 1'b1;
          hold_cnt_next = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          last_next    = sel_reg;
          timeout_next = wd_expire;
          if (pick_any) begin
            grant_next    = onehot4(pick_idx);
            sel_next      = pick_idx;
            hold_cnt_next = '0;
          end else begin
            state_next = IDLE;
            grant_next = '0;
            busy_next  = 1'b0;
          end
        end else if (!req[sel_reg]) begin
          // Abandon: the owner withdrew; idle one cycle before re-arbitrating.
          last_next  = sel_reg;
          state_next = IDLE;
          grant_next = '0;
          busy_next  = 1'b0;
        end else begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      last_reg     <= 2'd3;
      hold_cnt_reg <= '0;
      grant_reg    <= '0;
      sel_reg      <= 2'd0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      hold_cnt_reg <= hold_cnt_next;
      grant_reg    <= grant_next;
      sel_reg      <= sel_next;
      busy_reg     <= busy_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign grant   = grant_reg;
  assign sel     = sel_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;

endmodule
